// File: rtl/ieee_normalize_pack.sv
// ieee_normalize_pack: last stage of the binary32 adder. Serially normalizes the
// unnormalized sum, one bit per cycle. It then rounds, handles zero, overflow and
// underflow, and hands the packed word out through a valid/ready pair.
// Optional feature macro IEEE_NORM_RNE_EN: round to nearest, ties to even.
// Without it the block truncates (rounds toward zero).
module ieee_normalize_pack (
  input  logic        clock_in,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        sign_in,
  input  logic [7:0]  exp_in,
  input  logic [27:0] mant_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] outputC
);

  typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} stateT;

  stateT       state;
  logic        signReg;
  logic [8:0]  expReg;
  logic [27:0] mantReg;
  logic        zeroMark;

  logic        roundUp;
  logic [24:0] roundSum;
  logic [22:0] fracRounded;
  logic [8:0]  expRounded;
  logic        noHidden;

  // A new record can only be taken while nothing is in flight
  assign in_ready = (state == IDLE);

  // Round the normalized mantissa and fold a rounding carry back into the exponent
  always_comb begin
    roundUp = 1'b0;
`ifdef IEEE_NORM_RNE_EN
    roundUp = mantReg[2] & (mantReg[1] | mantReg[0] | mantReg[3]);
`endif
    roundSum    = {1'b0, mantReg[26:3]} + {24'd0, roundUp};
    fracRounded = roundSum[22:0];
    expRounded  = expReg;
    if (roundSum[24]) begin
      fracRounded = 23'd0;
      expRounded  = expReg + 9'd1;
    end
    noHidden = ~(roundSum[24] | roundSum[23]);
  end

  // Control FSM: load, shift toward the hidden bit, round/pack, then hold until taken
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      signReg   <= 1'b0;
      expReg    <= 9'd0;
      mantReg   <= 28'd0;
      zeroMark  <= 1'b0;
      out_valid <= 1'b0;
      outputC   <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            signReg  <= sign_in;
            expReg   <= {1'b0, exp_in};
            mantReg  <= mant_in;
            zeroMark <= 1'b0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (mantReg == 28'd0) begin
            zeroMark <= 1'b1;
            state    <= ROUND;
          end else if (expReg == 9'd0) begin
            zeroMark <= 1'b1;
            state    <= ROUND;
          end else if (mantReg[27]) begin
            mantReg <= {1'b0, mantReg[27:2], mantReg[1] | mantReg[0]};
            expReg  <= expReg + 9'd1;
            state   <= ROUND;
          end else if (mantReg[26]) begin
            state <= ROUND;
          end else if (expReg == 9'd1) begin
            zeroMark <= 1'b1;
            state    <= ROUND;
          end else begin
            mantReg <= {mantReg[26:0], 1'b0};
            expReg  <= expReg - 9'd1;
          end
        end
        ROUND: begin
          if (expRounded >= 9'd255) begin
            outputC <= {signReg, 8'hFF, 23'h0};
          end else if (zeroMark | noHidden) begin
            outputC <= 32'h0000_0000;
          end else begin
            outputC <= {signReg, expRounded[7:0], fracRounded};
          end
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
